my_fsm: RTL and testbench



---
 rtl/my_fsm.sv | 49 ++++
 tb/tb_my_fsm.sv | 110 +++++++++++
 2 files changed

// File: rtl/my_fsm.sv
// Moore detector for the serial pattern 1-1-0-1 (first bit first), overlapping matches allowed.
// The detect flag comes straight from a register, so it cannot glitch on changes of the data input.
module my_fsm (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    S1101 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_out;

  // Next-state decode; encodings 5-7 fall back to IDLE.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = in ? S1    : IDLE;
      S1:      w_next = in ? S11   : IDLE;
      S11:     w_next = in ? S11   : S110;
      S110:    w_next = in ? S1101 : IDLE;
      S1101:   w_next = in ? S11   : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state and flag use <= so every register samples pre-edge values; the
  // flag is loaded from the next state, so it is high exactly while the state is S1101.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == S1101);
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_my_fsm.sv
// Directed bench for my_fsm: hand-computed out values after each rising edge,
// including overlap, near misses, asynchronous reset and constant input.
module tb_my_fsm;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in    = 1'b0;
  logic out;

  int n_checks = 0;
  int n_errors = 0;

  my_fsm dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: out=%b expected=%b", tag, actual, expected);
    end
  endtask

  // Present one bit, clock it in, and sample out 1 time unit after the edge.
  task automatic step(input string tag, input logic b, input logic exp_out);
    in = b;
    @(posedge clock);
    #1;
    check(tag, out, exp_out);
  endtask

  // Runs a bit string (first bit in MSB position) with a matching expected-output string.
  task automatic run_seq(input string tag, input int len, input logic [15:0] bits,
                         input logic [15:0] exp);
    for (int i = len - 1; i >= 0; i--)
      step($sformatf("%s[%0d]", tag, len - 1 - i), bits[i], exp[i]);
  endtask

  // Assert reset between edges, verify out drops at once, then release it clear of an edge.
  task automatic pulse_reset(input string tag);
    #1;
    reset = 1'b0;
    #1;
    check({tag, "_async"}, out, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    // 1. reset held for two edges, then three zeros
    in = 1'b0;
    #1;
    check("reset_immediate", out, 1'b0);
    repeat (2) begin
      @(posedge clock);
      #1;
      check("reset_held", out, 1'b0);
    end
    @(negedge clock);
    reset = 1'b1;
    run_seq("zeros", 3, 16'b000, 16'b000);

    // 2. single match, then a 0
    run_seq("match", 5, 16'b11010, 16'b00010);

    // 3. overlapping matches: pulses after bits 4 and 7 only
    run_seq("overlap", 7, 16'b1101101, 16'b0001001);
    step("overlap_tail", 1'b0, 1'b0);

    // 4. near misses
    run_seq("near_miss", 8, 16'b10111001, 16'b00000000);
    run_seq("triple1", 5, 16'b11101, 16'b00001);
    step("triple1_tail", 1'b0, 1'b0);

    // 5a. reset after partial 110: the prefix must be lost
    run_seq("partial", 3, 16'b110, 16'b000);
    pulse_reset("mid_partial");
    step("after_reset_1", 1'b1, 1'b0);
    step("after_reset_0", 1'b0, 1'b0);

    // 5b. reset while out is high clears it without waiting for an edge
    run_seq("pre_match", 4, 16'b1101, 16'b0001);
    pulse_reset("mid_match");
    check("mid_match_held", out, 1'b0);
    step("post_match_reset", 1'b1, 1'b0);
    step("post_match_reset2", 1'b0, 1'b0);

    // 6. constant ones never match
    run_seq("ones", 10, 16'b1111111111, 16'b0000000000);

    // 7. from S11 a 0 then 1 still matches after a long run of ones
    run_seq("ones_then_01", 2, 16'b01, 16'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
